// File: rtl/pixel_readout_pkg.sv
// Shared types and helpers for the pixel readout receiver.
// Sizes are capped at MAX_N lanes, IDX_MAX_W index bits and FRAME_MAX_W frame bits.
package pixel_readout_pkg;

  localparam int MAX_N       = 32;
  localparam int IDX_MAX_W   = 5;
  localparam int FRAME_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DRAIN,
    ST_WAIT_REL
  } state_t;

  typedef struct packed {
    logic [7:0]             data;
    logic [IDX_MAX_W-1:0]   idx;
    logic [FRAME_MAX_W-1:0] frame;
  } pix_entry_t;

  // A lane is enabled when its 2-bit READ field is nonzero.
  function automatic logic [MAX_N-1:0] lane_mask(input logic [2*MAX_N-1:0] code);
    logic [MAX_N-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_N; k++) begin
      m[k] = |code[2*k +: 2];
    end
    return m;
  endfunction

endpackage

// File: rtl/pixel_readout_capture_fifo.sv
// First-word-fall-through FIFO; a pop frees a slot for a push on the same edge, even when full.
module pixel_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Head is forced to zero while empty so outputs read back as zero after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/pixel_readout_capture.sv
// Array-side READ/DATA receiver: settle after each READ code, latch the bus,
// serialize enabled byte lanes into a FWFT FIFO tagged with lane index and frame.
module pixel_readout_capture
  import pixel_readout_pkg::*;
#(
  parameter int N          = 2,
  parameter int SETTLE     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_W    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              erase,
  input  logic [2*N-1:0]                    read,
  input  logic [8*N-1:0]                    data_in,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [7:0]                        m_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_idx,
  output logic [FRAME_W-1:0]                m_frame,
  output logic                              overflow,
  output logic                              busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2*N-1:0]     last_code_reg, last_code_next;
  logic [N-1:0]       mask_reg, mask_next, mask_rest;
  logic [8*N-1:0]     cap_reg;
  logic               erase_q_reg;
  logic [FRAME_W-1:0] frame_reg;
  logic               overflow_reg;

  logic               capture;
  logic               push;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [IDX_W-1:0]   lane_sel;
  logic [7:0]         cap_lane [N];
  logic [2*MAX_N-1:0] read_ext;
  logic [MAX_N-1:0]   read_mask_full;
  logic [N-1:0]       read_mask;
  pix_entry_t         wr_entry;
  pix_entry_t         rd_entry;
  logic [$bits(pix_entry_t)-1:0] rd_bits;

  always_comb begin
    read_ext          = '0;
    read_ext[2*N-1:0] = read;
  end

  assign read_mask_full = lane_mask(read_ext);
  assign read_mask      = read_mask_full[N-1:0];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign cap_lane[gi] = cap_reg[8*gi +: 8];
    end
    if (N < MAX_N) begin : g_mask_pad
      logic unused_mask_bits;
      assign unused_mask_bits = |read_mask_full[MAX_N-1:N];
    end
  endgenerate

  // Lowest pending lane goes out first; descending scan lets the last hit win.
  always_comb begin
    lane_sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_reg[k]) lane_sel = IDX_W'(k);
    end
  end

  assign mask_rest = mask_reg & (mask_reg - 1'b1);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    last_code_next = last_code_reg;
    mask_next      = mask_reg;
    capture        = 1'b0;
    push           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (read != '0) begin
          state_next     = ST_SETTLE;
          cnt_next       = '0;
          last_code_next = read;
        end
      end
      ST_SETTLE: begin
        if (read == '0) begin
          state_next = ST_IDLE;
        end else if (read != last_code_reg) begin
          cnt_next       = '0;
          last_code_next = read;
        end else if (cnt_reg == CNT_W'(SETTLE - 1)) begin
          capture    = 1'b1;
          mask_next  = read_mask;
          state_next = ST_DRAIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DRAIN: begin
        push      = 1'b1;
        mask_next = mask_rest;
        if (mask_rest == '0) state_next = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (read == '0) begin
          state_next = ST_IDLE;
        end else if (read != last_code_reg) begin
          state_next     = ST_SETTLE;
          cnt_next       = '0;
          last_code_next = read;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      last_code_reg <= '0;
      mask_reg      <= '0;
      cap_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      last_code_reg <= last_code_next;
      mask_reg      <= mask_next;
      if (capture) cap_reg <= data_in;
    end
  end

  // A drop on the same edge as an erase rise still flags overflow for the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      erase_q_reg  <= 1'b0;
      frame_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      erase_q_reg <= erase;
      if (erase && !erase_q_reg) begin
        frame_reg    <= frame_reg + 1'b1;
        overflow_reg <= 1'b0;
      end
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign fifo_pop = ~fifo_empty & m_ready;
  assign drop     = push & fifo_full & ~fifo_pop;

  always_comb begin
    wr_entry       = '0;
    wr_entry.data  = cap_lane[lane_sel];
    wr_entry.idx   = IDX_MAX_W'(lane_sel);
    wr_entry.frame = FRAME_MAX_W'(frame_reg);
  end

  pixel_byte_fifo #(
    .WIDTH ($bits(pix_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_entry),
    .pop       (fifo_pop),
    .pop_data  (rd_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_entry = pix_entry_t'(rd_bits);

  generate
    if (IDX_W < IDX_MAX_W) begin : g_idx_pad
      logic unused_idx_bits;
      assign unused_idx_bits = |rd_entry.idx[IDX_MAX_W-1:IDX_W];
    end
    if (FRAME_W < FRAME_MAX_W) begin : g_frame_pad
      logic unused_frame_bits;
      assign unused_frame_bits = |rd_entry.frame[FRAME_MAX_W-1:FRAME_W];
    end
  endgenerate

  assign m_valid  = ~fifo_empty;
  assign m_data   = rd_entry.data;
  assign m_idx    = rd_entry.idx[IDX_W-1:0];
  assign m_frame  = rd_entry.frame[FRAME_W-1:0];
  assign overflow = overflow_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: doc/pixel_readout_capture.md
Name: pixel_readout_capture

Overview:
Synthesizable readout receiver on the array side of the pixel DATA bus. It tracks the READ phase codes issued by the sensor sequencer and waits a settling interval after each code change. It then latches the tristate bus, serializes the enabled pixel byte lanes and buffers them in a byte FIFO. Downstream logic drains the FIFO over a valid/ready stream tagged with pixel index and frame number.

Parameters:
N, 2, number of pixels (8-bit byte lanes) on DATA
SETTLE, 2, clk cycles from a new nonzero READ code to the bus sample (>=1)
FIFO_DEPTH, 8, byte entries in output FIFO (power of 2, >=2)
FRAME_W, 8, width of frame counter

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high reset
erase  in  1  sequencer ERASE phase; rising edge marks a new frame
read  in  2*N  READ code; bits [2k+1:2k] nonzero enable pixel lane k
data_in  in  8*N  DATA bus as seen at the array (lane k = bits [8k+7:8k])
m_valid  out  1  output byte available
m_ready  in  1  downstream accepts when m_valid & m_ready
m_data  out  8  pixel byte
m_idx  out  $clog2(N) (min 1)  pixel lane index of m_data
m_frame  out  FRAME_W  frame number of m_data
overflow  out  1  sticky: a byte was dropped on full FIFO
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async): FSM=IDLE, settle cnt=0, FIFO empty, frame cnt=0, overflow=0, m_valid=0, m_data=0, m_idx=0, m_frame=0, busy=0, erase_q=0, last_code=0.
- erase registered (erase_q). Rising edge (erase & ~erase_q) at edge E: frame cnt +1 (wraps at 2^FRAME_W), overflow cleared. The new frame value tags bytes pushed at edges after E.
- FSM states: IDLE, SETTLE, DRAIN, WAIT_REL.
- IDLE: read!=0 -> SETTLE, cnt=0, last_code=read.
- SETTLE: cnt increments each cycle.
  - read==0 -> IDLE, no capture.
  - read!=last_code -> restart: cnt=0, last_code=read.
  - cnt==SETTLE-1 with read stable -> latch data_in into cap_reg and lane mask (mask[k]=|read[2k+1:2k]) -> DRAIN.
  - Capture edge = SETTLE cycles after the first edge that sees the nonzero code.
- DRAIN: pushes one byte per cycle, ascending lane order, enabled lanes only, entry={byte,idx,frame}.
  - First push is on the edge after capture.
  - read changes are ignored until all enabled lanes are pushed, then -> WAIT_REL.
- WAIT_REL:
  - read==0 -> IDLE.
  - read!=0 and !=last_code -> SETTLE, cnt=0, last_code=read.
  - read==last_code -> stay. One capture per code occurrence.
- FIFO full on push: byte dropped, overflow=1 (sticky until erase rise or reset), lane still counted as consumed.
- FIFO is first-word-fall-through: m_valid=!empty, m_data/m_idx/m_frame = head entry.
  - Pop and push in the same cycle are both legal, including when full (pop frees the slot).
  - Push-to-m_valid latency is 1 edge.
- Reset mid-operation: everything returns to reset values and FIFO contents are discarded.
- busy=1 in SETTLE, DRAIN, WAIT_REL.

Decomposition:
- Package pixel_readout_pkg:
  - state enum (IDLE, SETTLE, DRAIN, WAIT_REL)
  - lane-mask function (2*N read bits -> N mask bits)
  - FIFO entry struct {data[7:0], idx, frame}
- One sub-module pixel_byte_fifo: parameterized synchronous FWFT FIFO with full/empty and simultaneous push/pop.

Test Plan:
1. N=2, SETTLE=2, m_ready=1; erase pulse, then read=4'b1100 held 5 cycles with data_in=16'hA53C -> exactly one byte 8'hA5, idx=1, frame=1; m_valid rises 3 edges after the first read edge.
2. read=4'b1100 for 5 cycles, then 4'b0011 for 5 cycles, data_in=16'h7F10 -> bytes 8'h7F (idx 1) then 8'h10 (idx 0), both frame=1, no duplicates.
3. read=4'b1111, data_in=16'hBEEF -> 8'hEF idx 0 followed next cycle by 8'hBE idx 1; read dropped to 0 after 1 cycle in SETTLE on a later pass -> no push.
4. m_ready=0, FIFO_DEPTH=8, nine single-lane reads -> 8 entries held, overflow=1 after the 9th. Erase rise -> overflow=0 and frame increments. Release m_ready -> the 8 original bytes come out in order.
5. Assert reset during DRAIN of read=4'b1111 -> m_valid=0, overflow=0, m_frame=0, busy=0 immediately; no bytes after reset release until a new read code.
6. 256 erase pulses with FRAME_W=8 -> frame counter wraps to 0; next captured byte carries m_frame=0.
